// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths and control-bundle layout for the pipeline-stage registers.
// Stages pack I_ctrl/O_ctrl using the bit offsets below.
package pipe_stage_reg_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int PC_WIDTH       = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam int STAGE_DATA_W    = 128;
  localparam int STAGE_CTRL_W    = 24;
  localparam int STALL_CNT_DEF_W = 16;

  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_CTRL_W  = 24;
  localparam int EXMEM_CTRL_W = 8;
  localparam int MEMWB_CTRL_W = 4;

  localparam int CTRL_BRANCH    = 0;
  localparam int CTRL_MEMREAD   = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_REGWRITE  = 3;
  localparam int CTRL_MEMTOREG  = 4;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_ALUOP_LSB = 6;
  localparam int CTRL_ALUOP_W   = 4;

  // True when a control bundle can change architectural state.
  function automatic logic ctrlHasSideEffect(input logic [STAGE_CTRL_W-1:0] c);
    return c[CTRL_MEMWRITE] | c[CTRL_REGWRITE];
  endfunction
endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one valid+data+ctrl register. Clear drops valid and ctrl only;
// data is left alone so a bubble costs no data-path toggling.
module pipe_slot #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] inData,
  input  logic [CTRL_W-1:0] inCtrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= inData;
      ctrl  <= inCtrl;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready, flush and stall counter.
// Define SKID_BUF_EN for a two-entry skid variant with registered O_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W      = STAGE_DATA_W,
  parameter int CTRL_W      = STAGE_CTRL_W,
  parameter int STALL_CNT_W = STALL_CNT_DEF_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   I_valid,
  output logic                   O_ready,
  input  logic [DATA_W-1:0]      I_data,
  input  logic [CTRL_W-1:0]      I_ctrl,
  input  logic                   I_flush,
  output logic                   O_valid,
  input  logic                   I_ready,
  output logic [DATA_W-1:0]      O_data,
  output logic [CTRL_W-1:0]      O_ctrl,
  output logic [STALL_CNT_W-1:0] O_stallCycles
);
  logic              accept, mainLoad, mainClear;
  logic [DATA_W-1:0] mainInData;
  logic [CTRL_W-1:0] mainInCtrl;

  assign accept = I_valid & O_ready;

`ifdef SKID_BUF_EN
  logic              skidValid, skidLoad, skidClear, mainFree;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;

  assign O_ready  = ~skidValid;
  assign mainFree = ~O_valid | I_ready;

  // Skid drains first to keep accept order.
  assign mainLoad   = ~I_flush & mainFree & (skidValid | accept);
  assign mainClear  = I_flush | (mainFree & ~skidValid & ~accept);
  assign mainInData = skidValid ? skidData : I_data;
  assign mainInCtrl = skidValid ? skidCtrl : I_ctrl;

  assign skidLoad  = ~I_flush & accept & (~mainFree | skidValid);
  assign skidClear = I_flush | (mainFree & skidValid & ~accept);

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) uSkid (
    .clk    (clk),
    .rst    (rst),
    .load   (skidLoad),
    .clear  (skidClear),
    .inData (I_data),
    .inCtrl (I_ctrl),
    .valid  (skidValid),
    .data   (skidData),
    .ctrl   (skidCtrl)
  );
`else
  assign O_ready    = ~O_valid | I_ready;
  assign mainLoad   = ~I_flush & accept;
  assign mainClear  = I_flush | (O_valid & I_ready & ~accept);
  assign mainInData = I_data;
  assign mainInCtrl = I_ctrl;
`endif

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) uMain (
    .clk    (clk),
    .rst    (rst),
    .load   (mainLoad),
    .clear  (mainClear),
    .inData (mainInData),
    .inCtrl (mainInCtrl),
    .valid  (O_valid),
    .data   (O_data),
    .ctrl   (O_ctrl)
  );

  // Saturating; flush does not reset it, only rst does.
  always_ff @(negedge clk or posedge rst) begin
    if (rst)
      O_stallCycles <= '0;
    else if (O_valid & ~I_ready & ~I_flush & ~(&O_stallCycles))
      O_stallCycles <= O_stallCycles + 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios plus random traffic.
// Inputs change just after the rising edge and are sampled just before the falling edge.
module tb_pipe_stage_reg;
  localparam int DW = 128;
  localparam int CW = 24;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          I_valid, I_flush, I_ready, O_ready, O_valid;
  logic [DW-1:0] I_data, O_data;
  logic [CW-1:0] I_ctrl, O_ctrl;
  logic [SW-1:0] O_stallCycles;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;
  item_t q[$];

  int checks = 0;
  int errs   = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(SW)) dut (
    .clk           (clk),
    .rst           (rst),
    .I_valid       (I_valid),
    .O_ready       (O_ready),
    .I_data        (I_data),
    .I_ctrl        (I_ctrl),
    .I_flush       (I_flush),
    .O_valid       (O_valid),
    .I_ready       (I_ready),
    .O_data        (O_data),
    .O_ctrl        (O_ctrl),
    .O_stallCycles (O_stallCycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; returns at the pre-falling-edge sample point.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic f, input logic r);
    item_t it;
    @(posedge clk);
    #1;
    I_valid = v; I_data = d; I_ctrl = c; I_flush = f; I_ready = r;
    #2;
    if (!rst) begin
      if (f) q.delete();
      else if (v && O_ready) begin
        it.d = d; it.c = c;
        q.push_back(it);
      end
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1; I_valid = 1'b0; I_flush = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops on every release, checks bubble invariant otherwise.
  initial begin
    item_t e;
    forever begin
      @(posedge clk);
      #3;
      if (!rst) begin
        if (!O_valid) chk("bubble_ctrl", O_ctrl, '0);
        else if (I_ready && !I_flush) begin
          checks++;
          if (q.size() == 0) begin
            errs++;
            $display("FAIL sb_unexpected: got data %0h with nothing expected", O_data);
          end else begin
            e = q.pop_front();
            if (O_data !== e.d || O_ctrl !== e.c) begin
              errs++;
              $display("FAIL sb_order: got %0h/%0h expected %0h/%0h", O_data, O_ctrl, e.d, e.c);
            end
          end
        end
      end
    end
  end

  initial begin
    logic expRdy;
    rst = 1'b1; I_valid = 0; I_flush = 0; I_ready = 0; I_data = '0; I_ctrl = '0;
    #2;
    chk("rst_valid", O_valid, 0);
    chk("rst_ready", O_ready, 1);
    chk("rst_ctrl", O_ctrl, 0);
    chk("rst_cnt", O_stallCycles, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Streaming
    step(1, 1, 24'h1, 0, 1);
    step(1, 2, 24'h2, 0, 1); chk("stream_d1", O_data, 1);
    step(1, 3, 24'h3, 0, 1); chk("stream_d2", O_data, 2);
    step(0, 0, 0, 0, 1);     chk("stream_d3", O_data, 3);
    step(0, 0, 0, 0, 1);     chk("stream_drained", O_valid, 0);
    chk("stream_cnt", O_stallCycles, 0);

    // Stall with an offered entry
    step(1, 'hA5, 24'h0A5, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 'h5A, 24'h05A, 0, 0);
`ifdef SKID_BUF_EN
      expRdy = (i == 0);
`else
      expRdy = 1'b0;
`endif
      if (i == 0) chk("stall_ready_first", O_ready, expRdy);
      if (i == 4) chk("stall_ready_last", O_ready, 0);
      if (i == 4) chk("stall_data_held", O_data, 'hA5);
    end
    step(1, 'h5A, 24'h05A, 0, 1);
    chk("stall_cnt5", O_stallCycles, 5);
    chk("stall_release_data", O_data, 'hA5);
`ifdef SKID_BUF_EN
    chk("stall_release_ready", O_ready, 0);
`else
    chk("stall_release_ready", O_ready, 1);
`endif
    step(0, 0, 0, 0, 1); chk("stall_second", O_data, 'h5A);
    step(0, 0, 0, 0, 1); chk("stall_drained", O_valid, 0);

    // Flush with simultaneous accept
    step(1, 'h77, 24'hFFFFFF, 0, 1);
    step(1, 'h99, 24'h000ABC, 1, 0);
    chk("flush_pre_ctrl", O_ctrl, 24'hFFFFFF);
    step(0, 0, 0, 0, 0);
    chk("flush_valid", O_valid, 0);
    chk("flush_ctrl", O_ctrl, 0);
    chk("flush_data_held", O_data, 'h77);
    chk("flush_cnt", O_stallCycles, 5);
    step(0, 0, 0, 0, 1);
    chk("flush_no_ghost", O_valid, 0);

    // Saturation
    doReset();
    step(1, 'h33, 24'h1, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); chk("sat_cnt", O_stallCycles, 15);
    step(0, 0, 0, 0, 1); chk("sat_hold", O_stallCycles, 15);
    chk("sat_data", O_data, 'h33);
    step(0, 0, 0, 0, 1);

    // Reset mid-stall, between edges
    doReset();
    step(1, 'h44, 24'hFFF, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("mid_cnt", O_stallCycles, 2);
    rst = 1'b1; I_valid = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", O_valid, 0);
    chk("mid_rst_ctrl", O_ctrl, 0);
    chk("mid_rst_data", O_data, 0);
    chk("mid_rst_cnt", O_stallCycles, 0);
    chk("mid_rst_ready", O_ready, 1);
    @(posedge clk); #1; rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
           24'($urandom), ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("sb_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
